// File: rtl/mips_mem_unit_if.sv
// Request, data-memory and writeback signals of mips_mem_unit.
// master is the unit side; slave is the execute stage, memory and writeback side.
interface mips_mem_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] req_pc;

    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic [31:0] m_inst_addr;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic [31:0] rsp_pc;
    logic [4:0]  rsp_exc;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_rd, req_pc,
        input  m_data_rdata, rsp_ready,
        output req_ready, m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
        output rsp_valid, rsp_we, rsp_rd, rsp_data, rsp_pc, rsp_exc
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_rd, req_pc,
        output m_data_rdata, rsp_ready,
        input  req_ready, m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
        input  rsp_valid, rsp_we, rsp_rd, rsp_data, rsp_pc, rsp_exc
    );
endinterface

// File: rtl/mips_mem_unit.sv
// MIPS M/W memory unit: M slot drives the data bus, W slot holds load results.
// Define MEM_ALIGN_CHECK_EN to trap misaligned accesses (AdEL/AdES) instead of ignoring low bits.
module mips_mem_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic             clk,
    input logic             reset,
    mips_mem_unit_if.master bus
);
    typedef enum logic [2:0] {
        OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] pc;
    } m_slot_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic [4:0]  exc;
    } w_slot_t;

    m_slot_t     m_q, m_d;
    w_slot_t     w_q, w_d;
    logic        m_vld_q, m_vld_d;
    logic        w_vld_q, w_vld_d;
    logic        is_store, misalign, to_w, m_adv, req_ready;
    logic [4:0]  exc;
    logic [15:0] ld_h;
    logic [7:0]  ld_b;
    logic [31:0] ld_data;
    logic [3:0]  byteen;
    logic [31:0] wdata;

    assign is_store = (m_q.op == OP_SW) || (m_q.op == OP_SH) || (m_q.op == OP_SB);

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (m_q.op)
            OP_LW, OP_SW:         misalign = |m_q.addr[1:0];
            OP_LH, OP_LHU, OP_SH: misalign = m_q.addr[0];
            default:              misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign exc = misalign ? (is_store ? 5'd5 : 5'd4) : 5'd0;
    // Faulting stores need a W entry to report the exception, so they wait like loads.
    assign to_w      = !is_store || misalign;
    assign m_adv     = to_w ? (!w_vld_q || bus.rsp_ready) : 1'b1;
    assign req_ready = reset && (!m_vld_q || m_adv);

    always_comb begin
        ld_h = m_q.addr[1] ? bus.m_data_rdata[31:16] : bus.m_data_rdata[15:0];
        ld_b = bus.m_data_rdata[{m_q.addr[1:0], 3'b000} +: 8];
        case (m_q.op)
            OP_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
            OP_LHU:  ld_data = {16'h0, ld_h};
            OP_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
            OP_LBU:  ld_data = {24'h0, ld_b};
            default: ld_data = bus.m_data_rdata;
        endcase
    end

    always_comb begin
        byteen = 4'b0000;
        wdata  = 32'h0;
        if (m_vld_q && is_store && !misalign) begin
            case (m_q.op)
                OP_SW: begin
                    byteen = 4'b1111;
                    wdata  = m_q.wdata;
                end
                OP_SH: begin
                    byteen = m_q.addr[1] ? 4'b1100 : 4'b0011;
                    wdata  = {2{m_q.wdata[15:0]}};
                end
                default: begin
                    byteen = 4'b0001 << m_q.addr[1:0];
                    wdata  = {4{m_q.wdata[7:0]}};
                end
            endcase
        end
        // A store caught by reset must not reach memory at the reset edge.
        if (!reset) byteen = 4'b0000;
    end

    always_comb begin
        m_d     = m_q;
        m_vld_d = m_vld_q;
        w_d     = w_q;
        w_vld_d = w_vld_q;
        if (w_vld_q && bus.rsp_ready) w_vld_d = 1'b0;
        if (m_vld_q && m_adv) begin
            m_vld_d = 1'b0;
            if (to_w) begin
                w_vld_d  = 1'b1;
                w_d.we   = !is_store && !misalign && (m_q.rd != 5'd0);
                w_d.rd   = m_q.rd;
                w_d.data = misalign ? 32'h0 : ld_data;
                w_d.pc   = m_q.pc;
                w_d.exc  = exc;
            end
        end
        if (bus.req_valid && req_ready) begin
            m_vld_d  = 1'b1;
            m_d.op    = op_e'(bus.req_op);
            m_d.addr  = bus.req_addr;
            m_d.wdata = bus.req_wdata;
            m_d.rd    = bus.req_rd;
            m_d.pc    = bus.req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_vld_q <= 1'b0;
            w_vld_q <= 1'b0;
            m_q     <= '0;
            w_q     <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            w_vld_q <= w_vld_d;
            m_q     <= m_d;
            w_q     <= w_d;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.m_data_addr   = m_vld_q ? m_q.addr : 32'h0;
    assign bus.m_data_wdata  = wdata;
    assign bus.m_data_byteen = byteen;
    assign bus.m_inst_addr   = m_vld_q ? m_q.pc : RESET_PC;
    assign bus.rsp_valid     = w_vld_q;
    assign bus.rsp_we        = w_vld_q && w_q.we;
    assign bus.rsp_rd        = w_vld_q ? w_q.rd : 5'd0;
    assign bus.rsp_data      = w_vld_q ? w_q.data : 32'h0;
    assign bus.rsp_pc        = w_vld_q ? w_q.pc : RESET_PC;
    assign bus.rsp_exc       = w_vld_q ? w_q.exc : 5'd0;
endmodule

// File: tb/tb_mips_mem_unit.sv
// Directed bench for mips_mem_unit with a byte-enabled word memory model on the data bus.
module tb_mips_mem_unit;
    logic clk = 1'b0;
    logic reset;
    logic mem_clr;
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    mips_mem_unit_if bus ();
    mips_mem_unit #(.RESET_PC(32'h0000_3000)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    always_comb bus.m_data_rdata = mem[bus.m_data_addr[7:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.m_data_byteen[i]) mem[bus.m_data_addr[7:2]][8*i +: 8] <= bus.m_data_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                       input logic [4:0] rd, input logic [31:0] pc);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = w;
        bus.req_rd    = rd;
        bus.req_pc    = pc;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    // One clock edge passes; returns at the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        mem_clr = 1'b1;
        bus.rsp_ready = 1'b1;
        req(LW, 32'h0, 32'h0, 5'd0, 32'h0);
        idle();
        repeat (3) step();
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_inst_addr", bus.m_inst_addr, 32'h3000);
        chk("rst_rsp_pc", bus.rsp_pc, 32'h3000);
        chk("rst_byteen", {28'h0, bus.m_data_byteen}, 32'h0);
        chk("rst_addr", bus.m_data_addr, 32'h0);
        reset = 1'b1;
        mem_clr = 1'b0;
        step();
        chk("rel_req_ready", {31'h0, bus.req_ready}, 32'h1);

        // SW then LW to the same word
        req(SW, 32'h10, 32'h1234_5678, 5'd0, 32'h3000);
        step();
        chk("sw_byteen", {28'h0, bus.m_data_byteen}, 32'hf);
        chk("sw_inst", bus.m_inst_addr, 32'h3000);
        chk("sw_wdata", bus.m_data_wdata, 32'h1234_5678);
        chk("sw_addr", bus.m_data_addr, 32'h10);
        req(LW, 32'h10, 32'h0, 5'd2, 32'h3004);
        step();
        idle();
        chk("lw_byteen", {28'h0, bus.m_data_byteen}, 32'h0);
        chk("lw_inst", bus.m_inst_addr, 32'h3004);
        chk("lw_rsp_early", {31'h0, bus.rsp_valid}, 32'h0);
        step();
        chk("lw_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
        chk("lw_data", bus.rsp_data, 32'h1234_5678);
        chk("lw_we", {31'h0, bus.rsp_we}, 32'h1);
        chk("lw_rd", {27'h0, bus.rsp_rd}, 32'h2);
        chk("lw_pc", bus.rsp_pc, 32'h3004);
        chk("lw_exc", {27'h0, bus.rsp_exc}, 32'h0);
        step();
        chk("lw_drained", {31'h0, bus.rsp_valid}, 32'h0);

        // SB then LB/LBU
        req(SB, 32'h13, 32'h0000_00ab, 5'd0, 32'h3008);
        step();
        chk("sb_byteen", {28'h0, bus.m_data_byteen}, 32'h8);
        chk("sb_wdata", bus.m_data_wdata, 32'habab_abab);
        req(LB, 32'h13, 32'h0, 5'd3, 32'h300c);
        step();
        req(LBU, 32'h13, 32'h0, 5'd4, 32'h3010);
        step();
        idle();
        chk("lb_data", bus.rsp_data, 32'hffff_ffab);
        chk("lb_rd", {27'h0, bus.rsp_rd}, 32'h3);
        step();
        chk("lbu_data", bus.rsp_data, 32'h0000_00ab);
        chk("lbu_rd", {27'h0, bus.rsp_rd}, 32'h4);
        step();
        chk("lbu_drained", {31'h0, bus.rsp_valid}, 32'h0);

        // SH then LH/LHU/LW, back to back
        req(SH, 32'h22, 32'h0000_8001, 5'd0, 32'h3014);
        step();
        chk("sh_byteen", {28'h0, bus.m_data_byteen}, 32'hc);
        chk("sh_wdata", bus.m_data_wdata, 32'h8001_8001);
        req(LH, 32'h22, 32'h0, 5'd5, 32'h3018);
        step();
        req(LHU, 32'h22, 32'h0, 5'd6, 32'h301c);
        step();
        req(LW, 32'h20, 32'h0, 5'd7, 32'h3020);
        chk("lh_data", bus.rsp_data, 32'hffff_8001);
        step();
        idle();
        chk("lhu_data", bus.rsp_data, 32'h0000_8001);
        step();
        chk("lw20_data", bus.rsp_data, 32'h8001_0000);
        chk("lw20_rd", {27'h0, bus.rsp_rd}, 32'h7);
        step();

        req(SW, 32'h30, 32'hcafe_f00d, 5'd0, 32'h3024);
        step();
        idle();
        step();

        // load to r0 is delivered with we cleared
        req(LW, 32'h10, 32'h0, 5'd0, 32'h3028);
        step();
        idle();
        step();
        chk("r0_valid", {31'h0, bus.rsp_valid}, 32'h1);
        chk("r0_we", {31'h0, bus.rsp_we}, 32'h0);
        chk("r0_data", bus.rsp_data, 32'hab34_5678);
        step();

        // writeback stall with three back-to-back loads
        bus.rsp_ready = 1'b0;
        req(LW, 32'h10, 32'h0, 5'd8, 32'h3100);
        step();
        chk("st1_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("st1_addr", bus.m_data_addr, 32'h10);
        req(LW, 32'h20, 32'h0, 5'd9, 32'h3104);
        step();
        req(LW, 32'h30, 32'h0, 5'd10, 32'h3108);
        chk("st2_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("st2_addr", bus.m_data_addr, 32'h20);
        chk("st2_data", bus.rsp_data, 32'hab34_5678);
        step();
        chk("st3_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("st3_addr", bus.m_data_addr, 32'h20);
        chk("st3_rd", {27'h0, bus.rsp_rd}, 32'h8);
        step();
        chk("st4_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("st4_addr", bus.m_data_addr, 32'h20);
        chk("st4_byteen", {28'h0, bus.m_data_byteen}, 32'h0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("st4_ready_rel", {31'h0, bus.req_ready}, 32'h1);
        step();
        idle();
        chk("st5_data", bus.rsp_data, 32'h8001_0000);
        chk("st5_rd", {27'h0, bus.rsp_rd}, 32'h9);
        step();
        chk("st6_data", bus.rsp_data, 32'hcafe_f00d);
        chk("st6_rd", {27'h0, bus.rsp_rd}, 32'ha);
        step();
        chk("st7_valid", {31'h0, bus.rsp_valid}, 32'h0);

        // reset while a store sits in M
        req(SW, 32'h40, 32'hdead_beef, 5'd0, 32'h3200);
        step();
        idle();
        reset = 1'b0;
        step();
        chk("rs_byteen", {28'h0, bus.m_data_byteen}, 32'h0);
        chk("rs_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rs_inst", bus.m_inst_addr, 32'h3000);
        chk("rs_addr", bus.m_data_addr, 32'h0);
        reset = 1'b1;
        step();
        chk("rs_no_write", mem[16], 32'h0);
        req(LW, 32'h40, 32'h0, 5'd11, 32'h3204);
        step();
        idle();
        step();
        chk("rs_lw_data", bus.rsp_data, 32'h0);
        step();

        // misaligned accesses
        req(LW, 32'h11, 32'h0, 5'd12, 32'h3300);
        step();
        idle();
        step();
        chk("mis_lw_valid", {31'h0, bus.rsp_valid}, 32'h1);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_lw_exc", {27'h0, bus.rsp_exc}, 32'h4);
        chk("mis_lw_we", {31'h0, bus.rsp_we}, 32'h0);
`else
        chk("mis_lw_exc", {27'h0, bus.rsp_exc}, 32'h0);
        chk("mis_lw_data", bus.rsp_data, 32'hab34_5678);
`endif
        step();
        req(SH, 32'h21, 32'h0000_5555, 5'd0, 32'h3304);
        step();
        idle();
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_sh_byteen", {28'h0, bus.m_data_byteen}, 32'h0);
        step();
        chk("mis_sh_valid", {31'h0, bus.rsp_valid}, 32'h1);
        chk("mis_sh_exc", {27'h0, bus.rsp_exc}, 32'h5);
        chk("mis_sh_we", {31'h0, bus.rsp_we}, 32'h0);
        step();
        chk("mis_sh_mem", mem[8], 32'h8001_0000);
`else
        chk("mis_sh_byteen", {28'h0, bus.m_data_byteen}, 32'h3);
        step();
        chk("mis_sh_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("mis_sh_mem", mem[8], 32'h8001_5555);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
